// File: rtl/mmss_down_timer_pkg.sv
// Shared types and helpers for the MM:SS countdown timer: state encoding,
// BCD digit width and the per-position digit modulus.
package mmss_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Digit 1 is the tens-of-seconds position; every other digit is decimal.
    function automatic int digit_mod(input int idx, input int sec_tens_mod);
        return (idx == 1) ? sec_tens_mod : 10;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d, input int m);
        return (int'(d) >= m) ? BCD_W'(m - 1) : d;
    endfunction

endpackage

// File: rtl/mmss_down_timer_if.sv
// Control/status bundle between the keypad/load logic (master) and the timer (slave).
interface mmss_down_timer_if
    import mmss_timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();

    logic                          load;
    logic [BCD_W*NUM_DIGITS-1:0]   load_val;
    logic                          start;
    logic                          pause;
    logic                          cancel;
    logic [BCD_W*NUM_DIGITS-1:0]   digits;
    logic                          running;
    logic                          zero;
    logic                          done;

    modport master (
        output load, load_val, start, pause, cancel,
        input  digits, running, zero, done
    );

    modport slave (
        input  load, load_val, start, pause, cancel,
        output digits, running, zero, done
    );

endinterface

// File: rtl/mmss_down_timer_digit.sv
// One BCD down-counting digit with modulus MOD; borrows out when decremented at zero.
module bcd_down_digit
    import mmss_timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             Cn,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             bout
);

    logic [BCD_W-1:0] q_reg;

    always_ff @(posedge clk or negedge Cn) begin
        if (!Cn) begin
            q_reg <= '0;
        end else if (ld) begin
            q_reg <= ld_val;
        end else if (dec) begin
            q_reg <= (q_reg == '0) ? BCD_W'(MOD - 1) : q_reg - 1'b1;
        end
    end

    assign q    = q_reg;
    assign bout = dec & (q_reg == '0);

endmodule

// File: rtl/mmss_down_timer.sv
// MM:SS countdown timer: one-second prescaler, start/pause/cancel FSM, clamp-on-load
// and a chain of BCD digits whose borrows ripple upward.
module mmss_down_timer
    import mmss_timer_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 100,
    parameter int SEC_TENS_MOD = 6
) (
    input  logic               clk,
    input  logic               Cn,
    mmss_down_timer_if.slave   bus
);

    localparam int W  = BCD_W * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic            running_reg;
    logic            done_reg;
    logic            tick;
    logic            terminal;
    logic            digit_ld;
    logic [W-1:0]    digit_ld_val;
    logic [W-1:0]    clamped;
    logic [W-1:0]    count;
    logic            count_zero;
    logic            count_one;
    logic [NUM_DIGITS:0] borrow;
    logic            unused_top_borrow;

    assign count_zero = (count == '0);
    assign count_one  = (count == W'(1));

    // A tick applied to a count of one is the terminal decrement.
    assign terminal = tick & count_one;

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        tick         = 1'b0;
        digit_ld     = 1'b0;
        digit_ld_val = clamped;
        unique case (state_reg)
            IDLE: begin
                if (bus.cancel) begin
                    digit_ld     = 1'b1;
                    digit_ld_val = '0;
                    presc_next   = '0;
                end else if (bus.load) begin
                    digit_ld = 1'b1;
                end else if (bus.start && !count_zero) begin
                    state_next = RUN;
                    presc_next = '0;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    digit_ld     = 1'b1;
                    digit_ld_val = '0;
                    presc_next   = '0;
                    state_next   = IDLE;
                end else if (bus.pause) begin
                    state_next = PAUSED;
                end else if (presc_reg == PW'(TICK_DIV - 1)) begin
                    tick       = 1'b1;
                    presc_next = '0;
                    if (count_one) begin
                        state_next = DONE;
                    end
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
            end
            PAUSED: begin
                if (bus.cancel) begin
                    digit_ld     = 1'b1;
                    digit_ld_val = '0;
                    presc_next   = '0;
                    state_next   = IDLE;
                end else if (bus.load) begin
                    digit_ld   = 1'b1;
                    state_next = IDLE;
                end else if (!bus.pause && bus.start) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (bus.cancel) begin
                    digit_ld     = 1'b1;
                    digit_ld_val = '0;
                    presc_next   = '0;
                    state_next   = IDLE;
                end else if (bus.load) begin
                    digit_ld   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Cn) begin
        if (!Cn) begin
            state_reg   <= IDLE;
            presc_reg   <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            running_reg <= (state_next == RUN);
            done_reg    <= terminal;
        end
    end

    assign borrow[0] = tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign clamped[gi*BCD_W +: BCD_W] =
                clamp_digit(bus.load_val[gi*BCD_W +: BCD_W], digit_mod(gi, SEC_TENS_MOD));

            bcd_down_digit #(
                .MOD(digit_mod(gi, SEC_TENS_MOD))
            ) u_digit (
                .clk    (clk),
                .Cn     (Cn),
                .ld     (digit_ld),
                .ld_val (digit_ld_val[gi*BCD_W +: BCD_W]),
                .dec    (borrow[gi]),
                .q      (count[gi*BCD_W +: BCD_W]),
                .bout   (borrow[gi+1])
            );
        end
    endgenerate

    // RUN is left before the count could borrow out of the top digit.
    assign unused_top_borrow = borrow[NUM_DIGITS];

    assign bus.digits  = count;
    assign bus.running = running_reg;
    assign bus.zero    = count_zero;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_mmss_down_timer.sv
// Bench for mmss_down_timer: integer-seconds reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_mmss_down_timer;
    import mmss_timer_pkg::*;

    localparam int ND  = 4;
    localparam int TD  = 4;
    localparam int STM = 6;
    localparam int W   = ND * BCD_W;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    typedef struct {
        int val;
        int mode;
        int pre;
        bit done;
    } model_t;

    logic clk = 1'b0;
    logic cn  = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;
    model_t m;

    always #5 clk = ~clk;

    mmss_down_timer_if #(.NUM_DIGITS(ND)) bus ();

    mmss_down_timer #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .SEC_TENS_MOD (STM)
    ) dut (
        .clk (clk),
        .Cn  (cn),
        .bus (bus)
    );

    function automatic int dmod(int i);
        return (i == 1) ? STM : 10;
    endfunction

    // Place value of digit i in the mixed-radix count.
    function automatic int wt(int i);
        int w = 1;
        for (int k = 0; k < i; k++) w = w * dmod(k);
        return w;
    endfunction

    function automatic int load_value(logic [W-1:0] v);
        int s = 0;
        for (int i = 0; i < ND; i++) begin
            int d = int'(v[i*BCD_W +: BCD_W]);
            if (d > dmod(i) - 1) d = dmod(i) - 1;
            s = s + d * wt(i);
        end
        return s;
    endfunction

    function automatic logic [W-1:0] show(int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            int d = (v / wt(i)) % dmod(i);
            r[i*BCD_W +: BCD_W] = d[BCD_W-1:0];
        end
        return r;
    endfunction

    function automatic model_t step(model_t s, logic ld, logic [W-1:0] lv,
                                    logic st, logic pa, logic ca);
        model_t n = s;
        n.done = 1'b0;
        if (ca) begin
            n.val = 0; n.pre = 0; n.mode = M_IDLE;
        end else begin
            case (s.mode)
                M_IDLE: begin
                    if (ld) n.val = load_value(lv);
                    else if (st && s.val != 0) begin n.mode = M_RUN; n.pre = 0; end
                end
                M_RUN: begin
                    if (pa) n.mode = M_PAUSED;
                    else if (s.pre == TD - 1) begin
                        n.pre = 0;
                        n.val = s.val - 1;
                        if (n.val == 0) begin n.mode = M_DONE; n.done = 1'b1; end
                    end else n.pre = s.pre + 1;
                end
                M_PAUSED: begin
                    if (ld) begin n.val = load_value(lv); n.mode = M_IDLE; end
                    else if (!pa && st) n.mode = M_RUN;
                end
                default: begin
                    if (ld) begin n.val = load_value(lv); n.mode = M_IDLE; end
                end
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge cn) begin
        if (!cn) m <= '{val: 0, mode: M_IDLE, pre: 0, done: 1'b0};
        else     m <= step(m, bus.load, bus.load_val, bus.start, bus.pause, bus.cancel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        bus.load = 1'b1; bus.load_val = v;
        cyc();
        bus.load = 1'b0;
        $display("load %h -> digits %h", v, bus.digits);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        $display("start -> running=%0b digits=%h", bus.running, bus.digits);
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
        $display("pause -> running=%0b digits=%h", bus.running, bus.digits);
    endtask

    task automatic pulse_cancel();
        bus.cancel = 1'b1; cyc(); bus.cancel = 1'b0;
        $display("cancel -> running=%0b digits=%h", bus.running, bus.digits);
    endtask

    initial begin
        bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0;
        bus.pause = 1'b0; bus.cancel = 1'b0;
        fork
            begin : compare
                while (!stim_done) begin
                    @(negedge clk);
                    if (cn === 1'b1) begin
                        chk("cyc_digits",  32'(bus.digits),  32'(show(m.val)));
                        chk("cyc_running", 32'(bus.running), 32'(m.mode == M_RUN));
                        chk("cyc_zero",    32'(bus.zero),    32'(m.val == 0));
                        chk("cyc_done",    32'(bus.done),    32'(m.done));
                    end
                end
            end
            begin : stim
                cyc(2);
                chk("rst_digits",  32'(bus.digits),  32'h0);
                chk("rst_running", 32'(bus.running), 32'h0);
                chk("rst_zero",    32'(bus.zero),    32'h1);
                chk("rst_done",    32'(bus.done),    32'h0);
                cn = 1'b1;
                cyc();

                // 00:03 counts down on every fourth clock and pulses done once.
                do_load(16'h0003);
                chk("t1_load", 32'(bus.digits), 32'h0003);
                pulse_start();
                chk("t1_run", 32'(bus.running), 32'h1);
                cyc(3); chk("t1_pre_tick", 32'(bus.digits), 32'h0003);
                cyc();  chk("t1_tick1", 32'(bus.digits), 32'h0002);
                cyc(4); chk("t1_tick2", 32'(bus.digits), 32'h0001);
                cyc(4); chk("t1_tick3", 32'(bus.digits), 32'h0000);
                chk("t1_done", 32'(bus.done), 32'h1);
                chk("t1_run_fall", 32'(bus.running), 32'h0);
                cyc();  chk("t1_done_once", 32'(bus.done), 32'h0);

                // 01:00 borrows through both seconds digits.
                do_load(16'h0100);
                pulse_start();
                cyc(4); chk("t2_borrow", 32'(bus.digits), 32'h0059);
                pulse_cancel();

                // Pause freezes both count and prescaler phase.
                do_load(16'h0010);
                pulse_start();
                cyc(4); chk("t3_tick", 32'(bus.digits), 32'h0009);
                cyc(2);
                pulse_pause();
                chk("t3_paused", 32'(bus.running), 32'h0);
                cyc(20); chk("t3_frozen", 32'(bus.digits), 32'h0009);
                pulse_start();
                chk("t3_resume", 32'(bus.running), 32'h1);
                cyc(); chk("t3_pre", 32'(bus.digits), 32'h0009);
                cyc(); chk("t3_tick2", 32'(bus.digits), 32'h0008);
                pulse_cancel();

                // Start on a zero count stays idle.
                do_load(16'h0000);
                pulse_start();
                chk("t4_idle", 32'(bus.running), 32'h0);
                cyc(6);
                chk("t4_nodone", 32'(bus.done), 32'h0);

                // Clamp on load, then cancel mid-run.
                do_load(16'h0079);
                chk("t5_clamp", 32'(bus.digits), 32'h0059);
                pulse_start();
                cyc(4); chk("t5_tick", 32'(bus.digits), 32'h0058);
                pulse_cancel();
                chk("t5_cancel", 32'(bus.digits), 32'h0000);
                chk("t5_run", 32'(bus.running), 32'h0);
                cyc(); chk("t5_nodone", 32'(bus.done), 32'h0);

                // Asynchronous reset between edges while running at 0005.
                do_load(16'h0007);
                pulse_start();
                cyc(8); chk("t6_at5", 32'(bus.digits), 32'h0005);
                #1 cn = 1'b0;
                #1;
                chk("t6_rst_digits",  32'(bus.digits),  32'h0);
                chk("t6_rst_running", 32'(bus.running), 32'h0);
                chk("t6_rst_zero",    32'(bus.zero),    32'h1);
                $display("async reset -> digits=%h running=%0b", bus.digits, bus.running);
                cyc(); cn = 1'b1;
                cyc(2); chk("t6_after", 32'(bus.running), 32'h0);
                do_load(16'h0005);
                pulse_start();
                chk("t6_restart", 32'(bus.running), 32'h1);
                cyc(24);

                // Randomized traffic; the per-cycle compare does the checking.
                for (int i = 0; i < 4000; i++) begin
                    int r = int'($urandom_range(0, 2));
                    bus.load = ($urandom_range(0, 99) < 8);
                    if (r == 0)      bus.load_val = {12'h000, 4'($urandom)};
                    else if (r == 1) bus.load_val = {8'h00, 8'($urandom)};
                    else             bus.load_val = 16'($urandom);
                    bus.start  = ($urandom_range(0, 99) < 30);
                    bus.pause  = ($urandom_range(0, 99) < 3);
                    bus.cancel = ($urandom_range(0, 99) < 1);
                    if ($urandom_range(0, 599) == 0) begin
                        #1 cn = 1'b0;
                        cyc();
                        cn = 1'b1;
                        $display("rnd %0d async reset", i);
                    end else begin
                        cyc();
                    end
                end
                bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.cancel = 1'b0;
                cyc(2);
                stim_done = 1'b1;
            end
        join
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
